// File: rtl/basic_alu_pkg.sv
// Purpose: shared opcode encodings and the opcode type for the basic_alu slice.
// Contents:
//   OP_ADD / OP_SUB / OP_AND / OP_OR  2-bit opcode encodings
//   alu_op_t                          2-bit enum built on those encodings
package basic_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_AND = OP_AND,
    ALU_OR  = OP_OR
  } alu_op_t;

endpackage

// File: rtl/basic_alu_core.sv
// Purpose: combinational compute for the basic ALU (no state).
// Ports:
//   a_i, b_i   in   WIDTH  unsigned operands
//   op_i       in   2      opcode (see basic_alu_pkg)
//   result_o   out  WIDTH  result modulo 2^WIDTH
//   carry_o    out  1      ADD carry-out, SUB borrow (a<b), 0 for logic ops
module basic_alu_core
  import basic_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  alu_op_t        op;

  assign op = alu_op_t'(op_i);

  // Both arithmetic paths are computed at WIDTH+1 bits; the top bit of the
  // difference is set exactly when a < b, which is the borrow.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op)
      ALU_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      ALU_SUB: begin
        result_o = diff[WIDTH-1:0];
        carry_o  = diff[WIDTH];
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/basic_alu.sv
// Purpose: registered single-cycle execute-stage ALU (ADD/SUB/AND/OR).
//   Inputs are sampled on a rising clk edge when in_valid is high; result,
//   carry, zero and out_valid appear one cycle later. Without in_valid the
//   data outputs hold and out_valid drops.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/op_code valid this cycle
//   a, b       in   WIDTH  unsigned operands
//   op_code    in   2      00=ADD 01=SUB 10=AND 11=OR
//   result     out  WIDTH  registered result
//   carry      out  1      carry-out / borrow, 0 for logic ops
//   zero       out  1      registered result == 0
//   out_valid  out  1      outputs valid strobe
module basic_alu
  import basic_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op_code,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             zero_d,   zero_q;
  logic             vld_d,    vld_q;

  basic_alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a),
    .b_i      (b),
    .op_i     (op_code),
    .result_o (result_d),
    .carry_o  (carry_d)
  );

  // zero is derived from the freshly computed result so it lands in the same
  // cycle as the result it describes.
  assign zero_d = (result_d == '0);
  assign vld_d  = in_valid;

  // Stage boundary: operands -> registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (in_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_basic_alu.sv
module tb_basic_alu;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] res;
    logic       cy;
    logic       zf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             out_valid;

  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];
  exp_t last_exp;

  basic_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op_code   (op_code),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic, modulo 256.
  function automatic exp_t model(input logic [1:0] op, input int ua, input int ub);
    exp_t e;
    int   t;
    t = 0;
    e.cy = 1'b0;
    case (op)
      2'b00: begin t = ua + ub;             e.cy = (t > 255); end
      2'b01: begin t = (ua - ub + 256) % 256; e.cy = (ua < ub); end
      2'b10: t = ua & ub;
      default: t = ua | ub;
    endcase
    e.res = t[7:0];
    e.zf  = (t % 256) == 0;
    return e;
  endfunction

  task automatic apply(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb);
    @(posedge clk); #1;
    in_valid = 1'b1;
    op_code  = op;
    a        = va;
    b        = vb;
    sb_q.push_back(model(op, int'(va), int'(vb)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      op_code  = 2'($urandom);
    end
  endtask

  // Monitor: pop and compare on valid output, otherwise check the hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("carry",  carry,  e.cy);
          chk("zero",   zero,   e.zf);
          last_exp = e;
        end
      end else begin
        chk("hold_result", result, last_exp.res);
        chk("hold_carry",  carry,  last_exp.cy);
        chk("hold_zero",   zero,   last_exp.zf);
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op_code  = 2'b00;

    #3;
    chk("rst_result", result, 0);
    chk("rst_carry",  carry,  0);
    chk("rst_zero",   zero,   0);
    chk("rst_valid",  out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed cases.
    apply(2'b00, 8'd10,  8'd5);
    apply(2'b00, 8'd255, 8'd1);
    apply(2'b01, 8'd10,  8'd5);
    apply(2'b01, 8'd5,   8'd10);
    apply(2'b10, 8'b10101010, 8'b11001100);
    apply(2'b11, 8'b10101010, 8'b11001100);
    apply(2'b01, 8'd7,   8'd7);
    apply(2'b11, 8'd0,   8'd0);
    apply(2'b10, 8'hF0,  8'h0F);
    apply(2'b00, 8'd200, 8'd100);
    idle(3);

    // Hold after a non-zero result, then four back-to-back ops.
    apply(2'b00, 8'd10, 8'd5);
    idle(3);
    apply(2'b00, 8'd1,  8'd2);
    apply(2'b01, 8'd0,  8'd1);
    apply(2'b10, 8'hFF, 8'h3C);
    apply(2'b11, 8'h81, 8'h18);
    idle(2);

    // Random streaming with occasional gaps.
    for (int i = 0; i < 40; i++) begin
      apply(2'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    apply(2'b00, 8'd10, 8'd5);
    idle(2);

    // Asynchronous reset mid-cycle with a non-zero result held.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_carry",  carry,  0);
    chk("arst_zero",   zero,   0);
    chk("arst_valid",  out_valid, 0);
    last_exp = '0;
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    chk("post_rst_result", result, 0);
    chk("post_rst_valid",  out_valid, 0);
    apply(2'b01, 8'd10, 8'd5);
    idle(3);

    chk("drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
